fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drain stage placed directly downstream of the synchronous FIFO: pops one word at a time through the FIFO's read port and serialises it as an asynchronous UART frame (start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit). It pops a new word only when the previous frame has fully left the line, so the FIFO absorbs bursty producers while this block paces output at the configured bit rate.

## Interface

- DATA_WIDTH, 8, width of the FIFO word and of the serialised data field
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- fifo_empty  input  1  FIFO empty flag
- read_data  input  DATA_WIDTH  FIFO read data, valid the cycle after a read_enable pulse
- read_enable  output  1  FIFO pop request, one-cycle pulse per word
- tx  output  1  serial line, idle high
- busy  output  1  high whenever state is not IDLE
- tx_done  output  1  one-cycle pulse in the final cycle of each stop bit

## Operation

- Reset values: tx=1, read_enable=0, busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY (only with macro), STOP.
- IDLE: tx=1; fifo_empty==0 sampled at an edge -> FETCH; else stay.
- FETCH: read_enable=1 for this single cycle (decoded from state register, glitch-free) -> LOAD.
- LOAD: capture read_data into shift register at end of cycle -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift[0]; after CLKS_PER_BIT cycles shift right; after DATA_WIDTH bits -> PARITY or STOP.
- PARITY: tx=even parity (XOR of captured word) for CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 in last cycle -> IDLE.
- Baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, reloads 0 at each bit boundary; bit counter width $clog2(DATA_WIDTH+1).
- fifo_empty is ignored outside IDLE; read_enable never asserted while fifo_empty==1 at the deciding edge.
- Reset mid-frame: tx returns to 1 asynchronously, frame aborted, captured word discarded (not re-popped).

## Timing

- Start latency: !fifo_empty first sampled at edge k -> read_enable high cycle k+1 -> LOAD cycle k+2 -> tx falls cycle k+3.
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles; +CLKS_PER_BIT with parity.
- Back-to-back words: exactly 3 idle-high cycles (IDLE, FETCH, LOAD) between stop-bit end and next start bit.
- Exactly one read_enable pulse per transmitted frame; no pop during any active frame.
- busy rises the cycle after the IDLE->FETCH decision and falls the cycle after tx_done.

## Configuration

- UART_TX_PARITY_EN defined: PARITY state present, even parity bit inserted between last data bit and stop; frame = (DATA_WIDTH+3)*CLKS_PER_BIT.
- Undefined: PARITY state and parity logic absent; DATA goes directly to STOP.

## Test plan

- Reset then idle, fifo_empty=1 for 100 cycles -> tx=1, read_enable=0, busy=0, tx_done=0 throughout.
- CLKS_PER_BIT=4, one word 0xA5 -> single read_enable pulse; tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; tx_done once at cycle 40 of frame.
- Three words 0x00,0xFF,0x3C queued -> three pulses, three frames in order, 3-cycle idle gaps, FIFO ends empty.
- UART_TX_PARITY_EN, word 0x07 -> parity bit 1 after data, frame 44 cycles at CLKS_PER_BIT=4; word 0x03 -> parity 0.
- Assert reset during DATA bit 3 of 0x5A -> tx=1 immediately, busy=0; after release with FIFO holding 0x81, next frame is 0x81.
- fifo_empty toggling 1-cycle low pulses mid-frame -> no read_enable until frame ends and IDLE samples empty=0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining UART transmitter; even parity bit enabled by UART_TX_PARITY_EN
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // Last clk cycle of the current UART bit period
  assign bit_end = (baud_cnt == BAUD_LAST);

  // Busy covers the whole fetch-to-stop sequence so nothing upstream mistakes FETCH/LOAD for idle
  assign busy = (state != IDLE);

  // State register; reset forces IDLE so tx snaps high without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Baud/bit counters and the shift register; the captured word is dropped on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (state == IDLE || state == FETCH || state == LOAD || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state == LOAD) begin
        shift_reg <= read_data;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^read_data;
`endif
      end else if (state == DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
      end

      if (state == DATA && bit_end) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // Next-state and output decode; all outputs come straight from the state register and counters
  always_comb begin
    state_next  = state;
    tx          = 1'b1;
    read_enable = 1'b0;
    tx_done     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_next = FETCH;
      end
      FETCH: begin
        read_enable = 1'b1;
        state_next  = LOAD;
      end
      LOAD: begin
        state_next = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end && bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = parity_bit;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        tx_done = bit_end;
        if (bit_end) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - randomized self-checking bench for fifo_uart_tx with a line-level UART reference
module tb_fifo_uart_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] read_data;
  logic          read_enable;
  logic          tx;
  logic          busy;
  logic          tx_done;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .read_data   (read_data),
    .read_enable (read_enable),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model, scoreboard and line monitor state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sent_q[$];
  int            gaps_q[$];
  int            fifo_cnt = 0;
  logic          gate = 1'b0;
  logic          empty_prev = 1'b1;
  int            cyc = 0;
  int            pops = 0;
  int            frames_done = 0;
  int            nf = 0;
  int            re_cyc = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  int            pos = 0;
  logic          in_frame = 1'b0;
  logic          chk_busy_fall = 1'b0;
  logic [DW-1:0] cur_word = '0;

  assign fifo_empty = (fifo_cnt == 0) || gate;

  // Expected line level for UART bit index b of a frame carrying word w
  function automatic logic exp_bit(input logic [DW-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    sent_q.push_back(w);
    fifo_cnt = fifo_q.size();
    nf++;
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = 0;
    while (frames_done < n && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    check("frames_timeout", frames_done >= n, 1);
  endtask

  // Synchronous FIFO read port: data appears the cycle after the pop
  always @(posedge clk) begin
    cyc++;
    if (!reset && read_enable) begin
      check("pop_when_empty", empty_prev, 0);
      if (fifo_q.size() != 0) read_data <= fifo_q.pop_front();
      fifo_cnt = fifo_q.size();
    end
    empty_prev = fifo_empty;
  end

  // Line monitor: every cycle of a frame is compared with the ideal UART waveform of the next queued word
  always @(negedge clk) begin
    if (reset) begin
      in_frame      = 1'b0;
      pos           = 0;
      chk_busy_fall = 1'b0;
    end else begin
      if (read_enable) begin
        re_cyc = cyc;
        pops++;
        check("busy_on_fetch", busy, 1);
        check("pop_in_frame", in_frame, 0);
      end
      if (chk_busy_fall) begin
        check("busy_fall", busy, 0);
        chk_busy_fall = 1'b0;
      end
      if (!in_frame && tx == 1'b0) begin
        in_frame  = 1'b1;
        pos       = 0;
        start_cyc = cyc;
        check("frame_expected", sent_q.size() != 0, 1);
        cur_word = (sent_q.size() != 0) ? sent_q.pop_front() : '0;
        check("start_latency", cyc - re_cyc, 2);
        gaps_q.push_back(cyc - done_cyc);
      end
      if (in_frame) begin
        check("frame_bits", {tx, tx_done, busy},
              {exp_bit(cur_word, pos / CPB), (pos == FRAME - 1), 1'b1});
        pos++;
        if (pos == FRAME) begin
          in_frame = 1'b0;
          frames_done++;
          done_cyc = cyc;
          check("frame_len", done_cyc - start_cyc + 1, FRAME);
          chk_busy_fall = 1'b1;
        end
      end else begin
        check("idle_done", tx_done, 0);
      end
    end
  end

  initial begin
    int p0;
    int b;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {tx, read_enable, busy, tx_done}, 4'b1000);
    reset = 1'b0;

    // Idle with an empty FIFO
    repeat (100) begin
      @(negedge clk);
      check("idle_outs", {tx, read_enable, busy, tx_done}, 4'b1000);
    end

    // Single word
    push(8'hA5);
    wait_frames(nf);
    check("pops_single", pops, 1);

    // Three queued words back to back
    gaps_q.delete();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_frames(nf);
    check("pops_three", pops, 4);
    check("gap_count", gaps_q.size(), 3);
    if (gaps_q.size() >= 3) begin
      check("gap_1", gaps_q[1], 4);
      check("gap_2", gaps_q[2], 4);
    end
    check("fifo_drained", fifo_q.size(), 0);

    // Parity-sensitive words (odd and even popcount)
    push(8'h07);
    push(8'h03);
    wait_frames(nf);

    // Random words with random producer spacing
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      push(8'($urandom));
    end
    wait_frames(nf);
    check("pops_random", pops, nf);

    // Reset during data bit 3 of 0x5A; the word is discarded, not resent
    push(8'h5A);
    nf--;
    b = 0;
    while (!(in_frame && pos >= 4 * CPB + 2) && b < 500) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("reach_data3", in_frame && pos >= 4 * CPB + 2, 1);
    reset = 1'b1;
    #1;
    check("abort_outs", {tx, busy, read_enable}, 3'b100);
    push(8'h81);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_frames(nf);
    check("fifo_after_abort", fifo_q.size(), 0);

    // Brief not-empty pulses during a frame must not cause a pop
    push(8'h11);
    b = 0;
    while (!in_frame && b < 200) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("gate_frame_start", in_frame, 1);
    gate = 1'b1;
    push(8'h22);
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      gate = 1'b0;
      @(negedge clk);
      gate = 1'b1;
    end
    wait_frames(nf - 1);
    repeat (10) @(negedge clk);
    check("no_pop_gated", pops, p0);
    gate = 1'b0;
    wait_frames(nf);
    check("pop_after_gate", pops, p0 + 1);
    check("scoreboard_empty", sent_q.size(), 0);
    check("fifo_final", fifo_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
